cpu_ctrl: RTL and testbench
===========================

// Module: cpu_ctrl
// PURPOSE
// - Hardwired microcontroller for the TEC-8 style teaching CPU. It decodes the console switches, IR[7:4], flags and beat pulses W1..W3 into datapath control strobes.
// - It sits between the timing generator (T3, W1-W3) and the datapath (register file, 74181 ALU, PC, AR, memory).
// - Its only sequential state is the phase flag st0 and the latched console mode.
// PARAMETERS
// - none
// PORTS
// - t3      in   1  single clock; all state updates on rising edge
// - clr     in   1  reset, synchronous to t3, active-low
// - swc,swb,swa in 1 each  console mode {swc,swb,swa}
// - ir      in   4  opcode IR[7:4]
// - w1,w2,w3 in  1 each  beat pulses, at most one high
// - c,z     in   1 each  carry / zero flags
// - drw,pcinc,lpc,lar,pcadd,arinc,selctl,memw,stop,lir,ldz,ldc,cin,m,abus,sbus,mbus  out 1 each  datapath strobes
// - s       out  4  ALU function select S3..S0
// - short   out  1  end cycle after W1;  long  out 1  insert W3
// - sel3..sel0 out 1 each  register select (sel3:sel2 = dest/A, sel1:sel0 = B)
// BEHAVIOUR
// - Outputs are purely combinational from (st0, mode, ir, w*, c, z). Any output not listed below is 0.
// - While clr=0, all outputs are forced to 0. On a t3 rise with clr=0: st0<=0 and mode_q<=mode.
// - On a t3 rise with clr=1 and mode!=mode_q: st0<=0 and mode_q<=mode. A mode change always restarts the sequence.
// - Mode 001, write memory:
//   - st0=0, W1: sbus,lar,stop,short,selctl. Then st0<=1.
//   - st0=1, W1: sbus,memw,arinc,stop,short,selctl.
// - Mode 010, read memory:
//   - st0=0, W1: sbus,lar,stop,short,selctl. Then st0<=1.
//   - st0=1, W1: mbus,arinc,stop,short,selctl.
// - Mode 011, read registers: selctl,stop at both beats.
//   - W1: sel=0001.
//   - W2: sel=1011.
// - Mode 100, write registers: sbus,drw,stop,selctl at both beats.
//   - st0=0: W1 sel=0011; W2 sel=0100, then st0<=1.
//   - st0=1: W1 sel=1001; W2 sel=1110.
// - Mode 000, run:
//   - st0=0, W1: sbus,lpc,stop,short (load start PC). Then st0<=1.
//   - st0=1, W1: lir,pcinc (fetch).
//   - st0=1, W2/W3: decode ir as below.
//     - 0001 ADD, W2: s=1001,cin=1,abus,drw,ldz,ldc
//     - 0010 SUB, W2: s=0110,abus,drw,ldz,ldc
//     - 0011 AND, W2: m=1,s=1011,abus,drw,ldz
//     - 0100 INC, W2: s=0000,abus,drw,ldz,ldc
//     - 0101 LD, W2: m=1,s=1010,abus,lar,long. W3: mbus,drw
//     - 0110 ST, W2: m=1,s=1111,abus,lar,long. W3: m=1,s=1010,abus,memw
//     - 0111 JC, W2: pcadd=c
//     - 1000 JZ, W2: pcadd=z
//     - 1001 JMP, W2: m=1,s=1111,abus,lpc
//     - 1010 OUT, W2: m=1,s=1010,abus
//     - 1110 STP, W2: stop
//     - 0000 and all other codes: no strobes (NOP)
// - Modes 101,110,111: all outputs 0 and st0 held.
// - W3 strobes are asserted only when the W2 of the same cycle asserted long (LD/ST).
// - st0 changes only at the single t3 rise that falls inside the qualifying W pulse. Repeated rises inside the same pulse leave st0 at 1.
// TESTING
// - Reset: clr=0 for one t3 rise, all W high in turn -> every output 0, st0=0.
// - Mode 000, ir=0001, clr=1:
//   - first W1 -> sbus=lpc=stop=short=1.
//   - next W1 -> lir=pcinc=1.
//   - W2 -> s=1001,cin=abus=drw=ldz=ldc=1.
// - Mode 000, st0=1:
//   - ir=0111, c=0 -> W2 pcadd=0; c=1 -> pcadd=1.
//   - ir=1000, z=1 -> pcadd=1.
// - Mode 000, st0=1, ir=0101:
//   - W2 -> lar=long=1, s=1010, m=1.
//   - W3 -> mbus=drw=1.
//   - ir=0110, W3 -> memw=1, abus=1.
// - Mode 001: W1 -> lar=1; next W1 -> memw=arinc=1, lar=0; switch to 010 -> next W1 lar=1 again.
// - Mode 100 -> sel 0011,0100,1001,1110 with drw=1 across two cycles. Mode 011 -> sel 0001 then 1011, drw=0.

Source files
------------

// File: rtl/cpu_ctrl.sv
// cpu_ctrl
// Hardwired microcontroller for a TEC-8 style teaching CPU. It decodes the
// console mode switches, the opcode IR[7:4], the C/Z flags and the beat
// pulses W1..W3 into the datapath control strobes. The only state is the
// phase flag st0 and the latched console mode.
//
// Ports
//   t3            in   single clock, all state updates on the rising edge
//   clr           in   synchronous active-low reset
//   swc,swb,swa   in   console mode {swc,swb,swa}
//   ir[3:0]       in   opcode IR[7:4]
//   w1,w2,w3      in   beat pulses (at most one high)
//   c,z           in   carry / zero flags
//   drw..mbus     out  single-bit datapath strobes
//   s[3:0]        out  74181 function select S3..S0
//   short         out  end the machine cycle after W1
//   long          out  insert a W3 beat
//   sel3..sel0    out  register select (sel3:sel2 = dest/A, sel1:sel0 = B)
module cpu_ctrl (
  input  logic       t3,
  input  logic       clr,
  input  logic       swc,
  input  logic       swb,
  input  logic       swa,
  input  logic [3:0] ir,
  input  logic       w1,
  input  logic       w2,
  input  logic       w3,
  input  logic       c,
  input  logic       z,
  output logic       drw,
  output logic       pcinc,
  output logic       lpc,
  output logic       lar,
  output logic       pcadd,
  output logic       arinc,
  output logic       selctl,
  output logic       memw,
  output logic       stop,
  output logic       lir,
  output logic       ldz,
  output logic       ldc,
  output logic       cin,
  output logic       m,
  output logic       abus,
  output logic       sbus,
  output logic       mbus,
  output logic [3:0] s,
  output logic       short,
  output logic       long,
  output logic       sel3,
  output logic       sel2,
  output logic       sel1,
  output logic       sel0
);

  localparam logic [2:0] MODE_RUN  = 3'b000;
  localparam logic [2:0] MODE_WMEM = 3'b001;
  localparam logic [2:0] MODE_RMEM = 3'b010;
  localparam logic [2:0] MODE_RREG = 3'b011;
  localparam logic [2:0] MODE_WREG = 3'b100;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_INC = 4'b0100;
  localparam logic [3:0] OP_LD  = 4'b0101;
  localparam logic [3:0] OP_ST  = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_JMP = 4'b1001;
  localparam logic [3:0] OP_OUT = 4'b1010;
  localparam logic [3:0] OP_STP = 4'b1110;

  logic [2:0] mode;
  logic [2:0] mode_q, mode_d;
  logic       st0_q, st0_d;
  logic       set_st0;
  logic [3:0] sel;

  assign mode = {swc, swb, swa};
  assign sel3 = sel[3];
  assign sel2 = sel[2];
  assign sel1 = sel[1];
  assign sel0 = sel[0];

  always_comb begin
    drw = 1'b0; pcinc = 1'b0; lpc = 1'b0; lar = 1'b0; pcadd = 1'b0;
    arinc = 1'b0; selctl = 1'b0; memw = 1'b0; stop = 1'b0; lir = 1'b0;
    ldz = 1'b0; ldc = 1'b0; cin = 1'b0; m = 1'b0; abus = 1'b0;
    sbus = 1'b0; mbus = 1'b0; s = 4'b0000; short = 1'b0; long = 1'b0;
    sel = 4'b0000;
    set_st0 = 1'b0;
    mode_d  = mode_q;
    st0_d   = st0_q;

    if (clr) begin
      case (mode)
        MODE_WMEM, MODE_RMEM: begin
          if (w1) begin
            stop = 1'b1; short = 1'b1; selctl = 1'b1;
            if (!st0_q) begin
              // First beat loads AR from the switches.
              sbus = 1'b1; lar = 1'b1; set_st0 = 1'b1;
            end else if (mode == MODE_WMEM) begin
              sbus = 1'b1; memw = 1'b1; arinc = 1'b1;
            end else begin
              mbus = 1'b1; arinc = 1'b1;
            end
          end
        end
        MODE_RREG: begin
          if (w1 || w2) begin
            selctl = 1'b1; stop = 1'b1;
            sel = w1 ? 4'b0001 : 4'b1011;
          end
        end
        MODE_WREG: begin
          if (w1 || w2) begin
            sbus = 1'b1; drw = 1'b1; stop = 1'b1; selctl = 1'b1;
            if (!st0_q) begin
              sel     = w1 ? 4'b0011 : 4'b0100;
              set_st0 = w2;
            end else begin
              sel = w1 ? 4'b1001 : 4'b1110;
            end
          end
        end
        MODE_RUN: begin
          if (!st0_q) begin
            if (w1) begin
              // Load the start PC from the switches.
              sbus = 1'b1; lpc = 1'b1; stop = 1'b1; short = 1'b1;
              set_st0 = 1'b1;
            end
          end else if (w1) begin
            lir = 1'b1; pcinc = 1'b1;
          end else if (w2) begin
            case (ir)
              OP_ADD: begin s = 4'b1001; cin = 1'b1; abus = 1'b1; drw = 1'b1; ldz = 1'b1; ldc = 1'b1; end
              OP_SUB: begin s = 4'b0110; abus = 1'b1; drw = 1'b1; ldz = 1'b1; ldc = 1'b1; end
              OP_AND: begin m = 1'b1; s = 4'b1011; abus = 1'b1; drw = 1'b1; ldz = 1'b1; end
              OP_INC: begin s = 4'b0000; abus = 1'b1; drw = 1'b1; ldz = 1'b1; ldc = 1'b1; end
              OP_LD:  begin m = 1'b1; s = 4'b1010; abus = 1'b1; lar = 1'b1; long = 1'b1; end
              OP_ST:  begin m = 1'b1; s = 4'b1111; abus = 1'b1; lar = 1'b1; long = 1'b1; end
              OP_JC:  pcadd = c;
              OP_JZ:  pcadd = z;
              OP_JMP: begin m = 1'b1; s = 4'b1111; abus = 1'b1; lpc = 1'b1; end
              OP_OUT: begin m = 1'b1; s = 4'b1010; abus = 1'b1; end
              OP_STP: stop = 1'b1;
              default: ;
            endcase
          end else if (w3) begin
            // Only LD/ST request long, so only they own a W3 beat.
            case (ir)
              OP_LD:  begin mbus = 1'b1; drw = 1'b1; end
              OP_ST:  begin m = 1'b1; s = 4'b1010; abus = 1'b1; memw = 1'b1; end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end

    // A mode change restarts the sequence; otherwise st0 only ever sets.
    if (mode != mode_q) begin
      mode_d = mode;
      st0_d  = 1'b0;
    end else if (set_st0) begin
      st0_d = 1'b1;
    end
  end

  always_ff @(posedge t3) begin
    if (!clr) begin
      st0_q  <= 1'b0;
      mode_q <= mode;
    end else begin
      st0_q  <= st0_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
module tb_cpu_ctrl;

  logic t3 = 1'b0;
  logic clr = 1'b0;
  logic swc = 1'b0, swb = 1'b0, swa = 1'b0;
  logic [3:0] ir = 4'd0;
  logic w1 = 1'b0, w2 = 1'b0, w3 = 1'b0, c = 1'b0, z = 1'b0;
  logic drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, stop, lir;
  logic ldz, ldc, cin, m, abus, sbus, mbus, short_o, long_o;
  logic sel3, sel2, sel1, sel0;
  logic [3:0] s;
  logic [26:0] obs;

  int n_chk = 0;
  int n_fail = 0;

  // Bench-side view of the controller state.
  logic       m_st0 = 1'b0;
  logic [2:0] m_mode = 3'd0;

  cpu_ctrl dut (
    .t3(t3), .clr(clr), .swc(swc), .swb(swb), .swa(swa), .ir(ir),
    .w1(w1), .w2(w2), .w3(w3), .c(c), .z(z),
    .drw(drw), .pcinc(pcinc), .lpc(lpc), .lar(lar), .pcadd(pcadd),
    .arinc(arinc), .selctl(selctl), .memw(memw), .stop(stop), .lir(lir),
    .ldz(ldz), .ldc(ldc), .cin(cin), .m(m), .abus(abus), .sbus(sbus),
    .mbus(mbus), .s(s), .short(short_o), .long(long_o),
    .sel3(sel3), .sel2(sel2), .sel1(sel1), .sel0(sel0)
  );

  always #5 t3 = ~t3;

  assign obs = {drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, stop, lir,
                ldz, ldc, cin, m, abus, sbus, mbus, s, short_o, long_o,
                sel3, sel2, sel1, sel0};

  localparam logic [26:0] V_DRW    = 27'd1 << 26;
  localparam logic [26:0] V_PCINC  = 27'd1 << 25;
  localparam logic [26:0] V_LPC    = 27'd1 << 24;
  localparam logic [26:0] V_LAR    = 27'd1 << 23;
  localparam logic [26:0] V_PCADD  = 27'd1 << 22;
  localparam logic [26:0] V_ARINC  = 27'd1 << 21;
  localparam logic [26:0] V_SELCTL = 27'd1 << 20;
  localparam logic [26:0] V_MEMW   = 27'd1 << 19;
  localparam logic [26:0] V_STOP   = 27'd1 << 18;
  localparam logic [26:0] V_LIR    = 27'd1 << 17;
  localparam logic [26:0] V_LDZ    = 27'd1 << 16;
  localparam logic [26:0] V_LDC    = 27'd1 << 15;
  localparam logic [26:0] V_CIN    = 27'd1 << 14;
  localparam logic [26:0] V_M      = 27'd1 << 13;
  localparam logic [26:0] V_ABUS   = 27'd1 << 12;
  localparam logic [26:0] V_SBUS   = 27'd1 << 11;
  localparam logic [26:0] V_MBUS   = 27'd1 << 10;
  localparam logic [26:0] V_SHORT  = 27'd1 << 5;
  localparam logic [26:0] V_LONG   = 27'd1 << 4;

  function automatic logic [26:0] fs(input logic [3:0] v);
    return {17'd0, v, 6'd0};
  endfunction

  function automatic logic [26:0] fsel(input logic [3:0] v);
    return {23'd0, v};
  endfunction

  // Strobe set for a run-mode instruction at W2 (b==2) or W3 (b==3).
  function automatic logic [26:0] run_op(input logic [3:0] op, input int b,
                                         input logic ci, input logic zi);
    logic [26:0] w2v, w3v;
    w2v = '0; w3v = '0;
    if      (op == 4'd1)  w2v = fs(4'b1001) | V_CIN | V_ABUS | V_DRW | V_LDZ | V_LDC;
    else if (op == 4'd2)  w2v = fs(4'b0110) | V_ABUS | V_DRW | V_LDZ | V_LDC;
    else if (op == 4'd3)  w2v = V_M | fs(4'b1011) | V_ABUS | V_DRW | V_LDZ;
    else if (op == 4'd4)  w2v = V_ABUS | V_DRW | V_LDZ | V_LDC;
    else if (op == 4'd5)  w2v = V_M | fs(4'b1010) | V_ABUS | V_LAR | V_LONG;
    else if (op == 4'd6)  w2v = V_M | fs(4'b1111) | V_ABUS | V_LAR | V_LONG;
    else if (op == 4'd7)  w2v = ci ? V_PCADD : 27'd0;
    else if (op == 4'd8)  w2v = zi ? V_PCADD : 27'd0;
    else if (op == 4'd9)  w2v = V_M | fs(4'b1111) | V_ABUS | V_LPC;
    else if (op == 4'd10) w2v = V_M | fs(4'b1010) | V_ABUS;
    else if (op == 4'd14) w2v = V_STOP;
    // W3 exists only when W2 asked for a long cycle.
    if (w2v & V_LONG)
      w3v = (op == 4'd5) ? (V_MBUS | V_DRW) : (V_M | fs(4'b1010) | V_ABUS | V_MEMW);
    return (b == 2) ? w2v : ((b == 3) ? w3v : 27'd0);
  endfunction

  function automatic logic [26:0] model(input logic cl, input logic [2:0] md,
                                        input logic st0, input logic [3:0] op,
                                        input int b, input logic ci, input logic zi);
    logic [26:0] v;
    v = '0;
    if (!cl) return v;
    if (md == 3'd1 || md == 3'd2) begin
      if (b == 1) begin
        if (!st0)            v = V_SBUS | V_LAR | V_STOP | V_SHORT | V_SELCTL;
        else if (md == 3'd1) v = V_SBUS | V_MEMW | V_ARINC | V_STOP | V_SHORT | V_SELCTL;
        else                 v = V_MBUS | V_ARINC | V_STOP | V_SHORT | V_SELCTL;
      end
    end else if (md == 3'd3) begin
      if (b == 1) v = V_SELCTL | V_STOP | fsel(4'b0001);
      if (b == 2) v = V_SELCTL | V_STOP | fsel(4'b1011);
    end else if (md == 3'd4) begin
      if (b == 1 || b == 2) begin
        v = V_SBUS | V_DRW | V_STOP | V_SELCTL;
        if (b == 1) v |= fsel(st0 ? 4'b1001 : 4'b0011);
        else        v |= fsel(st0 ? 4'b1110 : 4'b0100);
      end
    end else if (md == 3'd0) begin
      if (!st0) begin
        if (b == 1) v = V_SBUS | V_LPC | V_STOP | V_SHORT;
      end else if (b == 1) begin
        v = V_LIR | V_PCINC;
      end else begin
        v = run_op(op, b, ci, zi);
      end
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [26:0] got, input logic [26:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One beat: drive inputs after the falling edge, compare against the
  // model, then advance the bench state for the coming rising edge.
  task automatic step(input string tag, input logic cl, input logic [2:0] md,
                      input logic [3:0] op, input int b, input logic ci, input logic zi);
    @(negedge t3);
    clr = cl; {swc, swb, swa} = md; ir = op; c = ci; z = zi;
    w1 = (b == 1); w2 = (b == 2); w3 = (b == 3);
    #1;
    check({tag, "_model"}, obs, model(cl, md, m_st0, op, b, ci, zi));
    if (!cl || md != m_mode) begin
      m_st0 = 1'b0;
      m_mode = md;
    end else if (!m_st0 && ((md <= 3'd2 && b == 1) || (md == 3'd4 && b == 2))) begin
      m_st0 = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with each beat high in turn.
    step("rst_w1", 1'b0, 3'd0, 4'd1, 1, 1'b1, 1'b1); check("rst_w1", obs, 27'd0);
    step("rst_w2", 1'b0, 3'd0, 4'd1, 2, 1'b1, 1'b1); check("rst_w2", obs, 27'd0);
    step("rst_w3", 1'b0, 3'd0, 4'd5, 3, 1'b1, 1'b1); check("rst_w3", obs, 27'd0);

    // Run mode.
    step("run_pc", 1'b1, 3'd0, 4'd1, 1, 1'b0, 1'b0);
    check("run_pc", obs, V_SBUS | V_LPC | V_STOP | V_SHORT);
    step("run_fetch", 1'b1, 3'd0, 4'd1, 1, 1'b0, 1'b0);
    check("run_fetch", obs, V_LIR | V_PCINC);
    step("run_add", 1'b1, 3'd0, 4'd1, 2, 1'b0, 1'b0);
    check("run_add", obs, fs(4'b1001) | V_CIN | V_ABUS | V_DRW | V_LDZ | V_LDC);
    step("jc_c0", 1'b1, 3'd0, 4'd7, 2, 1'b0, 1'b0); check("jc_c0", obs, 27'd0);
    step("jc_c1", 1'b1, 3'd0, 4'd7, 2, 1'b1, 1'b0); check("jc_c1", obs, V_PCADD);
    step("jz_z1", 1'b1, 3'd0, 4'd8, 2, 1'b0, 1'b1); check("jz_z1", obs, V_PCADD);
    step("ld_w2", 1'b1, 3'd0, 4'd5, 2, 1'b0, 1'b0);
    check("ld_w2", obs, V_M | fs(4'b1010) | V_ABUS | V_LAR | V_LONG);
    step("ld_w3", 1'b1, 3'd0, 4'd5, 3, 1'b0, 1'b0); check("ld_w3", obs, V_MBUS | V_DRW);
    step("st_w3", 1'b1, 3'd0, 4'd6, 3, 1'b0, 1'b0);
    check("st_w3", obs, V_M | fs(4'b1010) | V_ABUS | V_MEMW);
    step("add_w3", 1'b1, 3'd0, 4'd1, 3, 1'b0, 1'b0); check("add_w3", obs, 27'd0);

    // Write memory, then switch to read memory.
    step("wm_idle", 1'b1, 3'd1, 4'd0, 0, 1'b0, 1'b0); check("wm_idle", obs, 27'd0);
    step("wm_ar", 1'b1, 3'd1, 4'd0, 1, 1'b0, 1'b0);
    check("wm_ar", obs, V_SBUS | V_LAR | V_STOP | V_SHORT | V_SELCTL);
    step("wm_wr", 1'b1, 3'd1, 4'd0, 1, 1'b0, 1'b0);
    check("wm_wr", obs, V_SBUS | V_MEMW | V_ARINC | V_STOP | V_SHORT | V_SELCTL);
    step("rm_idle", 1'b1, 3'd2, 4'd0, 0, 1'b0, 1'b0);
    step("rm_ar", 1'b1, 3'd2, 4'd0, 1, 1'b0, 1'b0);
    check("rm_ar", obs, V_SBUS | V_LAR | V_STOP | V_SHORT | V_SELCTL);
    step("rm_rd", 1'b1, 3'd2, 4'd0, 1, 1'b0, 1'b0);
    check("rm_rd", obs, V_MBUS | V_ARINC | V_STOP | V_SHORT | V_SELCTL);

    // Write registers over two cycles.
    step("wr_idle", 1'b1, 3'd4, 4'd0, 0, 1'b0, 1'b0);
    step("wr_s0w1", 1'b1, 3'd4, 4'd0, 1, 1'b0, 1'b0);
    check("wr_s0w1", obs, V_SBUS | V_DRW | V_STOP | V_SELCTL | fsel(4'b0011));
    step("wr_s0w2", 1'b1, 3'd4, 4'd0, 2, 1'b0, 1'b0);
    check("wr_s0w2", obs, V_SBUS | V_DRW | V_STOP | V_SELCTL | fsel(4'b0100));
    step("wr_s1w1", 1'b1, 3'd4, 4'd0, 1, 1'b0, 1'b0);
    check("wr_s1w1", obs, V_SBUS | V_DRW | V_STOP | V_SELCTL | fsel(4'b1001));
    step("wr_s1w2", 1'b1, 3'd4, 4'd0, 2, 1'b0, 1'b0);
    check("wr_s1w2", obs, V_SBUS | V_DRW | V_STOP | V_SELCTL | fsel(4'b1110));

    // Read registers.
    step("rr_idle", 1'b1, 3'd3, 4'd0, 0, 1'b0, 1'b0);
    step("rr_w1", 1'b1, 3'd3, 4'd0, 1, 1'b0, 1'b0);
    check("rr_w1", obs, V_SELCTL | V_STOP | fsel(4'b0001));
    step("rr_w2", 1'b1, 3'd3, 4'd0, 2, 1'b0, 1'b0);
    check("rr_w2", obs, V_SELCTL | V_STOP | fsel(4'b1011));

    // Unused mode.
    step("m5_w1", 1'b1, 3'd5, 4'd0, 1, 1'b0, 1'b0); check("m5_w1", obs, 27'd0);

    // Randomized phase against the model.
    for (int i = 0; i < 600; i++) begin
      logic       rcl;
      logic [2:0] rmd;
      rcl = ($urandom_range(0, 31) != 0);
      rmd = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : m_mode;
      step("rand", rcl, rmd, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
